// File: rtl/servant_multi_timer.sv
// servant_multi_timer: prescaled free-running counter shared by NUM_CH
// compare channels (one-shot or auto-reload), Wishbone slave with real ack.
// Ports: i_clk, i_rst (sync, active high); i_wb_adr/dat/we/cyc in,
//   o_wb_rdt/o_wb_ack out; o_ch_irq = pending & irq_en; o_irq = |o_ch_irq.
module servant_multi_timer #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int PS_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_wb_adr,
   input  logic [31:0]       i_wb_dat,
   input  logic              i_wb_we,
   input  logic              i_wb_cyc,
   output logic [31:0]       o_wb_rdt,
   output logic              o_wb_ack,
   output logic [NUM_CH-1:0] o_ch_irq,
   output logic              o_irq
);

   logic [WIDTH-1:0]  mtime;
   logic [WIDTH-1:0]  mtime_inc;
   logic [PS_W-1:0]   prescale;
   logic [PS_W-1:0]   pcnt;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] irq_en;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] periodic;
   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] autoload;
   logic [WIDTH-1:0]  cmp    [NUM_CH];
   logic [WIDTH-1:0]  reload [NUM_CH];

   logic [3:0]        blk;
   logic [1:0]        word;
   logic              acc;
   logic              wr;
   logic              tick;
   logic              advance;
   logic              wr_mtime;
   logic              wr_ps;
   logic              wr_pend;
   logic              wr_ien;
   logic [NUM_CH-1:0] wr_cmp;
   logic [NUM_CH-1:0] wr_rel;
   logic [NUM_CH-1:0] wr_ctrl;
   logic [31:0]       rdata;
   logic              unused_ok;

   // blk 0 holds the global registers, blk c+1 holds channel c
   assign blk  = i_wb_adr[7:4];
   assign word = i_wb_adr[3:2];

   assign acc = i_wb_cyc & ~o_wb_ack;
   assign wr  = acc & i_wb_we;

   assign wr_mtime = wr & (blk == 4'd0) & (word == 2'd0);
   assign wr_ps    = wr & (blk == 4'd0) & (word == 2'd1);
   assign wr_pend  = wr & (blk == 4'd0) & (word == 2'd2);
   assign wr_ien   = wr & (blk == 4'd0) & (word == 2'd3);

   assign tick      = (pcnt == prescale);
   // a bus write of MTIME suppresses the increment and all matches
   assign advance   = tick & ~wr_mtime;
   assign mtime_inc = mtime + WIDTH'(1);

   always_comb begin
      wr_cmp   = '0;
      wr_rel   = '0;
      wr_ctrl  = '0;
      match    = '0;
      autoload = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wr_cmp[c]   = wr & (blk == 4'(c + 1)) & (word == 2'd0);
         wr_rel[c]   = wr & (blk == 4'(c + 1)) & (word == 2'd1);
         wr_ctrl[c]  = wr & (blk == 4'(c + 1)) & (word == 2'd2);
         match[c]    = advance & en[c] & (mtime_inc == cmp[c]);
         autoload[c] = periodic[c] & (reload[c] != '0);
      end
   end

   always_comb begin
      rdata = '0;
      if (blk == 4'd0) begin
         unique case (word)
            2'd0: rdata = 32'(mtime);
            2'd1: rdata = 32'(prescale);
            2'd2: rdata = 32'(pending);
            2'd3: rdata = 32'(irq_en);
         endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (blk == 4'(c + 1)) begin
            case (word)
               2'd0:    rdata = 32'(cmp[c]);
               2'd1:    rdata = 32'(reload[c]);
               2'd2:    rdata = {30'd0, periodic[c], en[c]};
               default: rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_ack <= 1'b0;
         o_wb_rdt <= '0;
         mtime    <= '0;
         prescale <= '0;
         pcnt     <= '0;
         pending  <= '0;
         irq_en   <= '0;
         en       <= '0;
         periodic <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cmp[c]    <= '0;
            reload[c] <= '0;
         end
      end else begin
         o_wb_ack <= acc;
         if (acc)
            o_wb_rdt <= rdata;

         if (wr_ps)
            prescale <= i_wb_dat[PS_W-1:0];
         if (wr_ps || tick)
            pcnt <= '0;
         else
            pcnt <= pcnt + PS_W'(1);

         if (wr_mtime)
            mtime <= i_wb_dat[WIDTH-1:0];
         else if (advance)
            mtime <= mtime_inc;

         // a new match beats a same-cycle write-1-to-clear
         pending <= (pending & ~({NUM_CH{wr_pend}} & i_wb_dat[NUM_CH-1:0]))
                  | match;

         if (wr_ien)
            irq_en <= i_wb_dat[NUM_CH-1:0];

         // bus writes take priority over the match side effects
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_cmp[c])
               cmp[c] <= i_wb_dat[WIDTH-1:0];
            else if (match[c] & autoload[c])
               cmp[c] <= cmp[c] + reload[c];

            if (wr_rel[c])
               reload[c] <= i_wb_dat[WIDTH-1:0];

            if (wr_ctrl[c]) begin
               en[c]       <= i_wb_dat[0];
               periodic[c] <= i_wb_dat[1];
            end else if (match[c] & ~autoload[c]) begin
               en[c] <= 1'b0;
            end
         end
      end
   end

   assign o_ch_irq = pending & irq_en;
   assign o_irq    = |o_ch_irq;

   assign unused_ok = &{1'b0, i_wb_adr[1:0], i_wb_dat};

endmodule

// File: tb/tb_servant_multi_timer.sv
// tb_servant_multi_timer: randomized + directed bench for servant_multi_timer
// (WIDTH=8 build) against a cycle-level register model.
module tb_servant_multi_timer;

   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     adr = '0;
   logic [31:0]    dat = '0;
   logic           we  = 1'b0;
   logic           cyc = 1'b0;
   logic [31:0]    rdt;
   logic           ack;
   logic [NCH-1:0] ch_irq;
   logic           irq;

   int n_cmp = 0;
   int n_bad = 0;

   int       m_mtime = 0;
   int       m_ps    = 0;
   int       m_pcnt  = 0;
   bit [3:0] m_pend  = '0;
   bit [3:0] m_ien   = '0;
   bit       m_ack   = 1'b0;
   logic [31:0] m_rdt = '0;
   int       m_cmp [NCH];
   int       m_rel [NCH];
   bit       m_en  [NCH];
   bit       m_per [NCH];

   servant_multi_timer #(.WIDTH(8), .NUM_CH(NCH), .PS_W(8)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wb_adr (adr),
      .i_wb_dat (dat),
      .i_wb_we  (we),
      .i_wb_cyc (cyc),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_ch_irq (ch_irq),
      .o_irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] a);
      int off;
      int c;
      logic [31:0] r;
      off = int'(a) & 'hFC;
      r = '0;
      if (off == 0) r = 32'(m_mtime);
      else if (off == 4) r = 32'(m_ps);
      else if (off == 8) r = 32'(m_pend);
      else if (off == 12) r = 32'(m_ien);
      else if (off >= 16 && off < 16 + 16 * NCH) begin
         c = (off - 16) / 16;
         case ((off - 16) % 16)
            0:       r = 32'(m_cmp[c]);
            4:       r = 32'(m_rel[c]);
            8:       r = {30'd0, m_per[c], m_en[c]};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // advance the model across one rising edge using the current inputs
   task automatic model_edge();
      bit acc, wr, tick, adv;
      int off, nmt, npc, base;
      bit [3:0] hit;
      logic [31:0] rd;
      if (rst) begin
         m_mtime = 0; m_ps = 0; m_pcnt = 0;
         m_pend = '0; m_ien = '0; m_ack = 1'b0; m_rdt = '0;
         for (int c = 0; c < NCH; c++) begin
            m_cmp[c] = 0; m_rel[c] = 0; m_en[c] = 0; m_per[c] = 0;
         end
      end else begin
         acc = cyc && !m_ack;
         wr  = acc && we;
         off = int'(adr) & 'hFC;
         rd  = model_read(adr);
         tick = (m_pcnt == m_ps);
         adv  = tick && !(wr && off == 0);
         if (wr && off == 0) nmt = int'(dat[7:0]);
         else if (adv) nmt = (m_mtime + 1) % 256;
         else nmt = m_mtime;
         npc = (wr && off == 4) ? 0 : (tick ? 0 : m_pcnt + 1);
         hit = '0;
         for (int c = 0; c < NCH; c++)
            hit[c] = adv && m_en[c] && (nmt == m_cmp[c]);
         if (wr && off == 8) m_pend = m_pend & ~dat[3:0];
         m_pend = m_pend | hit;
         for (int c = 0; c < NCH; c++) begin
            base = 16 + 16 * c;
            if (hit[c]) begin
               if (m_per[c] && m_rel[c] != 0)
                  m_cmp[c] = (m_cmp[c] + m_rel[c]) % 256;
               else
                  m_en[c] = 0;
            end
            if (wr && off == base) m_cmp[c] = int'(dat[7:0]);
            if (wr && off == base + 4) m_rel[c] = int'(dat[7:0]);
            if (wr && off == base + 8) begin
               m_en[c]  = dat[0];
               m_per[c] = dat[1];
            end
         end
         if (wr && off == 4) m_ps = int'(dat[7:0]);
         if (wr && off == 12) m_ien = dat[3:0];
         m_mtime = nmt;
         m_pcnt  = npc;
         if (acc) m_rdt = rd;
         m_ack = acc;
      end
   endtask

   task automatic step();
      bit [3:0] e;
      model_edge();
      @(posedge clk);
      #1;
      e = m_pend & m_ien;
      chk("ack", 32'(ack), 32'(m_ack));
      chk("irq", 32'({irq, ch_irq}), 32'({|e, e}));
   endtask

   task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
      cyc = 1'b1; we = 1'b1; adr = a; dat = d;
      step();
      cyc = 1'b0; we = 1'b0;
      step();
   endtask

   task automatic wb_rd(input logic [7:0] a, output logic [31:0] d);
      cyc = 1'b1; we = 1'b0; adr = a;
      step();
      chk("rdt", rdt, m_rdt);
      d = rdt;
      cyc = 1'b0;
      step();
   endtask

   task automatic wait_ch(input int b, input int lim);
      int n;
      n = 0;
      while (!ch_irq[b] && n < lim) begin
         step();
         n++;
      end
      chk("poll_ch", 32'(ch_irq[b]), 32'd1);
   endtask

   task automatic wait_mt(input int t);
      int n;
      n = 0;
      while (m_mtime != t && n < 600) begin
         step();
         n++;
      end
      if (m_mtime != t) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_mt got=%0d exp=%0d", m_mtime, t);
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  a;
      int k, cv, nv;

      step();
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 24; i++) begin
         a = 8'(4 * i);
         wb_rd(a, d);
      end
      wb_rd(8'hFC, d);
      chk("rst_ps", d, 0);

      // one-shot with prescale 3
      wb_wr(8'h04, 32'd3);
      wb_wr(8'h00, 32'd0);
      wb_wr(8'h10, 32'd5);
      wb_wr(8'h18, 32'd1);
      wb_wr(8'h0C, 32'd1);
      wait_ch(0, 60);
      wb_rd(8'h18, d);
      chk("oneshot_ctrl", d, 0);
      wb_wr(8'h08, 32'd1);
      chk("irq_clr", 32'(irq), 0);
      wb_wr(8'h04, 32'd0);
      repeat (600) step();
      chk("no_refire", 32'(irq), 0);

      // periodic channel 1, reload 4
      wb_wr(8'h0C, 32'd3);
      wb_wr(8'h28, 32'd0);
      wb_wr(8'h20, 32'd10);
      wb_wr(8'h24, 32'd4);
      wb_wr(8'h00, 32'd0);
      wb_wr(8'h28, 32'd3);
      for (int i = 0; i < 3; i++) begin
         wait_ch(1, 30);
         wb_wr(8'h08, 32'd2);
      end
      wb_wr(8'h28, 32'd0);
      wb_rd(8'h20, d);
      chk("cmp22", d, 22);

      // wrap with periodic ch0, then CMP=0 on wrap
      wb_wr(8'h04, 32'd7);
      wb_wr(8'h00, 32'hFE);
      wb_wr(8'h10, 32'h02);
      wb_wr(8'h14, 32'h03);
      wb_wr(8'h18, 32'd3);
      wb_wr(8'h0C, 32'd1);
      wb_wr(8'h08, 32'hF);
      wait_ch(0, 80);
      wb_rd(8'h10, d);
      chk("wrap_cmp", d, 5);
      wb_wr(8'h10, 32'h00);
      wb_wr(8'h18, 32'd1);
      wb_wr(8'h08, 32'hF);
      wb_wr(8'h00, 32'hFD);
      wait_ch(0, 60);
      wb_rd(8'h00, d);
      chk("wrap0", d, 0);

      // same-cycle collisions
      wb_wr(8'h04, 32'd0);
      wb_wr(8'h0C, 32'hF);
      wb_wr(8'h08, 32'hF);
      cv = (m_mtime + 20) % 256;
      wb_wr(8'h30, 32'(cv));
      wb_wr(8'h38, 32'd1);
      wait_mt((cv + 255) % 256);
      wb_wr(8'h08, 32'd4);
      wb_rd(8'h08, d);
      chk("w1c_vs_set", 32'(d[2]), 1);
      wb_wr(8'h08, 32'hF);

      cv = (m_mtime + 20) % 256;
      wb_wr(8'h40, 32'(cv));
      wb_wr(8'h48, 32'd1);
      wait_mt((cv + 255) % 256);
      nv = (cv + 128) % 256;
      wb_wr(8'h00, 32'(nv));
      wb_rd(8'h00, d);
      chk("mt_write", d, 32'((nv + 1) % 256));
      wb_rd(8'h08, d);
      chk("mt_nomatch", 32'(d[3]), 0);
      wb_wr(8'h48, 32'd0);

      cv = (m_mtime + 20) % 256;
      wb_wr(8'h30, 32'(cv));
      wb_wr(8'h34, 32'd5);
      wb_wr(8'h38, 32'd3);
      wait_mt((cv + 255) % 256);
      nv = (cv + 100) % 256;
      wb_wr(8'h30, {24'hA5A5A5, 8'(nv)});
      wb_rd(8'h30, d);
      chk("cmp_write", d, 32'(nv));
      wb_rd(8'h08, d);
      chk("cmp_match", 32'(d[2]), 1);
      wb_wr(8'h38, 32'd0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         k = $urandom_range(0, 99);
         case ($urandom_range(0, 5))
            0: a = 8'h00;
            1: a = 8'h04;
            2: a = 8'h08;
            3: a = 8'h0C;
            4: a = 8'(16 + 16 * $urandom_range(0, 3) + 4 * $urandom_range(0, 3));
            default: a = 8'($urandom_range(0, 255));
         endcase
         a[1:0] = 2'($urandom_range(0, 3));
         d = $urandom;
         if ((a & 8'hFC) == 8'h04) d[7:0] = 8'($urandom_range(0, 3));
         if (k < 50) wb_wr(a, d);
         else if (k < 85) wb_rd(a, d);
         else repeat ($urandom_range(1, 4)) step();
      end

      // reset during a held read while an interrupt is active
      wb_wr(8'h04, 32'd0);
      wb_wr(8'h18, 32'd0);
      wb_wr(8'h0C, 32'hF);
      wb_wr(8'h08, 32'hF);
      wb_wr(8'h10, 32'((m_mtime + 6) % 256));
      wb_wr(8'h18, 32'd1);
      wait_ch(0, 40);
      chk("irq_hi", 32'(irq), 1);
      cyc = 1'b1; we = 1'b0; adr = 8'h00;
      rst = 1'b1;
      step();
      chk("rst_rdt", rdt, 0);
      rst = 1'b0;
      step();
      chk("rst_mtime", rdt, 0);
      cyc = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
